// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of one asynchronous SRAM.
// Each transaction is SETUP, a WAIT_CYC-cycle ACCESS window, then a one-cycle
// DONE that pulses the owner's ack.
// Build option: define SRAM_ARB_FIXED_PRI_EN to replace round-robin with fixed
// priority, so port 0 always wins a tie. Port 1 can then be starved.
module sram_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          ce,
  output logic          oe,
  output logic          we,
  output logic [1:0]    gnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last counter value of the ACCESS window.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_owner;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
`ifndef SRAM_ARB_FIXED_PRI_EN
  logic          r_rr_last;
`endif

  logic          w_grant;
  logic          w_pick1;
  logic          w_last;
  logic          w_drive;

  // Arbitration: pick the winner for a grant taken in IDLE.
  always_comb begin
    w_grant = (r_state == IDLE) && (req0 || req1);
`ifdef SRAM_ARB_FIXED_PRI_EN
    w_pick1 = req1 && !req0;
`else
    // On a tie, the port that did not win last time goes next.
    w_pick1 = req1 && (!req0 || !r_rr_last);
`endif
    w_last  = (r_cnt == CNT_LAST);
  end

  // State register and the control/command registers latched at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_rdata   <= '0;
`ifndef SRAM_ARB_FIXED_PRI_EN
      r_rr_last <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ACCESS) ? r_cnt + 4'd1 : 4'd0;
      if (w_grant) begin
        r_owner   <= w_pick1;
        r_wr      <= w_pick1 ? wr1 : wr0;
        r_addr    <= w_pick1 ? addr1 : addr0;
`ifndef SRAM_ARB_FIXED_PRI_EN
        r_rr_last <= w_pick1;
`endif
      end
      // Capture on the edge that closes the read strobe window.
      if ((r_state == ACCESS) && !r_wr && w_last)
        r_rdata <= sram_data;
    end
  end

  // Write data is only meaningful while the owner is writing; no reset needed.
  always_ff @(posedge clk) begin
    if (w_grant)
      r_wdata <= w_pick1 ? wdata1 : wdata0;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req0 || req1) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes, bus enable and handshake outputs decoded from the current state.
  always_comb begin
    ce      = 1'b1;
    oe      = 1'b1;
    we      = 1'b1;
    ack0    = 1'b0;
    ack1    = 1'b0;
    w_drive = 1'b0;
    busy    = (r_state != IDLE);
    gnt     = 2'b00;
    case (r_state)
      SETUP: begin
        ce      = 1'b0;
        w_drive = r_wr;
      end
      ACCESS: begin
        ce = 1'b0;
        if (r_wr) begin
          we      = 1'b0;
          w_drive = 1'b1;
        end else begin
          oe = 1'b0;
        end
      end
      DONE: begin
        ack0 = !r_owner;
        ack1 = r_owner;
      end
      default: ;
    endcase
    if (busy)
      gnt = r_owner ? 2'b10 : 2'b01;
  end

  // The bus is released on the same edge that raises we, so data holds through it.
  assign sram_data = w_drive ? r_wdata : {DW{1'bz}};
  assign sram_addr = r_addr;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: main instance with WAIT_CYC=2 against a
// behavioural SRAM, plus WAIT_CYC=1 and WAIT_CYC=15 instances for timing.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, ce, oe, we, busy;
  logic [1:0] gnt;
  logic [3:0] rdata, sram_addr;
  wire  [3:0] sram_data;

  logic [3:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #50 clk = ~clk;

  // Behavioural asynchronous SRAM: drives data while ce and oe are low,
  // stores data on clock edges while ce and we are low.
  assign sram_data = (!ce && !oe) ? mem[sram_addr] : 4'bzzzz;
  always @(posedge clk) if (!rst && !ce && !we) mem[sram_addr] <= sram_data;

  sram_arbiter #(.AW(4), .DW(4), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .sram_addr(sram_addr),
    .sram_data(sram_data), .ce(ce), .oe(oe), .we(we), .gnt(gnt), .busy(busy)
  );

  // Timing instances: port 0 writes only.
  logic       x1_req = 1'b0, x15_req = 1'b0;
  logic       x1_ack0, x1_ack1, x1_ce, x1_oe, x1_we, x1_busy;
  logic       x15_ack0, x15_ack1, x15_ce, x15_oe, x15_we, x15_busy;
  logic [1:0] x1_gnt, x15_gnt;
  logic [3:0] x1_rdata, x1_addr, x15_rdata, x15_addr;
  wire  [3:0] x1_data, x15_data;

  sram_arbiter #(.AW(4), .DW(4), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .rst(rst), .req0(x1_req), .req1(1'b0), .wr0(1'b1), .wr1(1'b0),
    .addr0(4'h2), .addr1(4'h0), .wdata0(4'h5), .wdata1(4'h0),
    .ack0(x1_ack0), .ack1(x1_ack1), .rdata(x1_rdata), .sram_addr(x1_addr),
    .sram_data(x1_data), .ce(x1_ce), .oe(x1_oe), .we(x1_we), .gnt(x1_gnt), .busy(x1_busy)
  );

  sram_arbiter #(.AW(4), .DW(4), .WAIT_CYC(15)) u_w15 (
    .clk(clk), .rst(rst), .req0(x15_req), .req1(1'b0), .wr0(1'b1), .wr1(1'b0),
    .addr0(4'h2), .addr1(4'h0), .wdata0(4'h5), .wdata1(4'h0),
    .ack0(x15_ack0), .ack1(x15_ack1), .rdata(x15_rdata), .sram_addr(x15_addr),
    .sram_data(x15_data), .ce(x15_ce), .oe(x15_oe), .we(x15_we), .gnt(x15_gnt), .busy(x15_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; x1_req = 1'b0; x15_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction on one port; returns edge latency from grant to ack and strobe-low counts.
  task automatic run_txn(input bit port, input bit w, input logic [3:0] a, input logic [3:0] d,
                         output int lat, output int ce_lo, output int oe_lo, output int we_lo,
                         output logic [1:0] g, output logic [3:0] rd);
    lat = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; g = 2'b00; rd = 4'h0;
    @(negedge clk);
    if (port) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) g = gnt;
      if (!ce) ce_lo++;
      if (!oe) oe_lo++;
      if (!we) we_lo++;
      if (port ? ack1 : ack0) begin
        lat = n - 1;
        rd  = rdata;
        if (port) req1 = 1'b0; else req0 = 1'b0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    #20;
    n_cmp++; if ({ce, oe, we} !== 3'b111) begin n_bad++; $display("FAIL reset_strobes: got %b want 111", {ce, oe, we}); end
    n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({rdata, sram_addr} !== 8'h00) begin n_bad++; $display("FAIL reset_rdata_addr: got %h want 00", {rdata, sram_addr}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    int lat, ce_lo, oe_lo, we_lo, acks;
    logic [1:0] g;
    logic [3:0] rd;
    run_txn(1'b0, 1'b1, 4'h3, 4'hA, lat, ce_lo, oe_lo, we_lo, g, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_lat: got %0d want 3", lat); end
    n_cmp++; if (ce_lo !== 3) begin n_bad++; $display("FAIL write_ce_low: got %0d want 3", ce_lo); end
    n_cmp++; if (we_lo !== 2) begin n_bad++; $display("FAIL write_we_low: got %0d want 2", we_lo); end
    n_cmp++; if (oe_lo !== 0) begin n_bad++; $display("FAIL write_oe_low: got %0d want 0", oe_lo); end
    n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL write_gnt: got %b want 01", g); end
    n_cmp++; if (mem[3] !== 4'hA) begin n_bad++; $display("FAIL write_mem: got %h want a", mem[3]); end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || busy) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL write_no_dup: got %0d busy/ack cycles want 0", acks); end
    n_cmp++; if (rdata !== 4'h0) begin n_bad++; $display("FAIL write_rdata_held: got %h want 0", rdata); end
  endtask

  task automatic test_read();
    int lat, ce_lo, oe_lo, we_lo;
    logic [1:0] g;
    logic [3:0] rd;
    run_txn(1'b1, 1'b0, 4'h3, 4'h0, lat, ce_lo, oe_lo, we_lo, g, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL read_lat: got %0d want 3", lat); end
    n_cmp++; if (oe_lo !== 2) begin n_bad++; $display("FAIL read_oe_low: got %0d want 2", oe_lo); end
    n_cmp++; if ({ce_lo, we_lo} !== {32'd3, 32'd0}) begin n_bad++; $display("FAIL read_ce_we: got ce %0d we %0d want 3 0", ce_lo, we_lo); end
    n_cmp++; if (g !== 2'b10) begin n_bad++; $display("FAIL read_gnt: got %b want 10", g); end
    n_cmp++; if (rd !== 4'hA) begin n_bad++; $display("FAIL read_rdata: got %h want a", rd); end
    run_txn(1'b0, 1'b1, 4'h7, 4'h5, lat, ce_lo, oe_lo, we_lo, g, rd);
    n_cmp++; if (rdata !== 4'hA) begin n_bad++; $display("FAIL rdata_hold_over_write: got %h want a", rdata); end
    n_cmp++; if (mem[7] !== 4'h5) begin n_bad++; $display("FAIL write2_mem: got %h want 5", mem[7]); end
  endtask

  task automatic test_tie();
    logic [1:0] gl [2];
    logic [1:0] prev;
    int gi, a0n, a1n;
    logic [3:0] rd0;
    do_reset();
    gl[0] = 2'b00; gl[1] = 2'b00; gi = 0; a0n = -1; a1n = -1; rd0 = 4'h0; prev = 2'b00;
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h3;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 4'h9; wdata1 = 4'hC;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev == 2'b00 && gi < 2) begin gl[gi] = gnt; gi++; end
      prev = gnt;
      if (ack0 && a0n < 0) begin a0n = n; rd0 = rdata; req0 = 1'b0; end
      if (ack1 && a1n < 0) begin a1n = n; req1 = 1'b0; end
      if (a0n >= 0 && a1n >= 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++; if (gl[0] !== 2'b01) begin n_bad++; $display("FAIL tie_first_gnt: got %b want 01", gl[0]); end
    n_cmp++; if (gl[1] !== 2'b10) begin n_bad++; $display("FAIL tie_second_gnt: got %b want 10", gl[1]); end
    n_cmp++; if (a0n !== 4) begin n_bad++; $display("FAIL tie_ack0_cycle: got %0d want 4", a0n); end
    n_cmp++; if (a1n !== 9) begin n_bad++; $display("FAIL tie_ack1_cycle: got %0d want 9", a1n); end
    n_cmp++; if (rd0 !== 4'hA) begin n_bad++; $display("FAIL tie_rdata: got %h want a", rd0); end
    n_cmp++; if (mem[9] !== 4'hC) begin n_bad++; $display("FAIL tie_mem: got %h want c", mem[9]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] gl [4];
    logic [1:0] want [4];
    logic [1:0] prev;
    int gi;
`ifdef SRAM_ARB_FIXED_PRI_EN
    want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b01; want[3] = 2'b01;
`else
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
`endif
    for (int i = 0; i < 4; i++) gl[i] = 2'b00;
    gi = 0; prev = 2'b00;
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h3;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h9;
    for (int n = 1; n <= 60 && gi < 4; n++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev == 2'b00) begin gl[gi] = gnt; gi++; end
      prev = gnt;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (gl[i] !== want[i]) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, gl[i], want[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, ce_lo, oe_lo, we_lo, acks;
    logic [1:0] g;
    logic [3:0] rd;
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h5; wdata0 = 4'h6;
    repeat (2) @(negedge clk);
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_access: we got %b want 0", we); end
    #10 rst = 1'b1;
    #1;
    n_cmp++; if ({ce, we} !== 2'b11) begin n_bad++; $display("FAIL rstmid_strobes: got ce/we %b want 11", {ce, we}); end
    n_cmp++; if ({gnt, busy} !== 3'b000) begin n_bad++; $display("FAIL rstmid_gnt_busy: got %b want 000", {gnt, busy}); end
    req0 = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    run_txn(1'b0, 1'b0, 4'h3, 4'h0, lat, ce_lo, oe_lo, we_lo, g, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_read_lat: got %0d want 3", lat); end
    n_cmp++; if (rd !== 4'hA) begin n_bad++; $display("FAIL rstmid_read_data: got %h want a", rd); end
  endtask

  task automatic test_wait_cyc();
    int lat1, lat15, we1, we15;
    bit d1, d15;
    do_reset();
    lat1 = -1; lat15 = -1; we1 = 0; we15 = 0; d1 = 1'b0; d15 = 1'b0;
    @(negedge clk);
    x1_req = 1'b1; x15_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!d1) begin
        if (!x1_we) we1++;
        if (x1_ack0) begin lat1 = n - 1; x1_req = 1'b0; d1 = 1'b1; end
      end
      if (!d15) begin
        if (!x15_we) we15++;
        if (x15_ack0) begin lat15 = n - 1; x15_req = 1'b0; d15 = 1'b1; end
      end
      if (d1 && d15) break;
    end
    x1_req = 1'b0; x15_req = 1'b0;
    n_cmp++; if (lat1 !== 2) begin n_bad++; $display("FAIL wc1_lat: got %0d want 2", lat1); end
    n_cmp++; if (we1 !== 1) begin n_bad++; $display("FAIL wc1_we_low: got %0d want 1", we1); end
    n_cmp++; if (lat15 !== 16) begin n_bad++; $display("FAIL wc15_lat: got %0d want 16", lat15); end
    n_cmp++; if (we15 !== 15) begin n_bad++; $display("FAIL wc15_we_low: got %0d want 15", we15); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_round_robin();
    test_reset_mid();
    test_wait_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
